// File: rtl/avalon_rsa_dma_if.sv
// Bus bundle for avalon_rsa_dma: Avalon-MM master, CSR slave and RSA core port.
// master = DMA side, slave = environment (memory, CPU, core).
interface avalon_rsa_dma_if #(
  parameter int DATA_W = 256,
  parameter int CORE_W = 8,
  parameter int ADDR_W = 32
);
  localparam int N    = DATA_W / CORE_W;
  localparam int CA_W = (N > 1) ? $clog2(N) : 1;

  logic              avm_m0_waitrequest;
  logic [ADDR_W-1:0] avm_m0_address;
  logic              avm_m0_read;
  logic              avm_m0_write;
  logic              avm_m0_readdatavalid;
  logic [DATA_W-1:0] avm_m0_readdata;
  logic [DATA_W-1:0] avm_m0_writedata;

  logic [2:0]        avs_s0_address;
  logic              avs_s0_read;
  logic              avs_s0_write;
  logic [31:0]       avs_s0_writedata;
  logic [31:0]       avs_s0_readdata;
  logic              avs_s0_waitrequest;

  logic              core_we;
  logic              core_oe;
  logic              core_start;
  logic [1:0]        core_reg_sel;
  logic [CA_W-1:0]   core_addr;
  logic [CORE_W-1:0] core_wdata;
  logic [CORE_W-1:0] core_rdata;
  logic              core_ready;

  modport master (
    input  avm_m0_waitrequest, avm_m0_readdatavalid, avm_m0_readdata,
    output avm_m0_address, avm_m0_read, avm_m0_write, avm_m0_writedata,
    input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    output avs_s0_readdata, avs_s0_waitrequest,
    output core_we, core_oe, core_start, core_reg_sel, core_addr, core_wdata,
    input  core_rdata, core_ready
  );

  modport slave (
    output avm_m0_waitrequest, avm_m0_readdatavalid, avm_m0_readdata,
    input  avm_m0_address, avm_m0_read, avm_m0_write, avm_m0_writedata,
    output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    input  avs_s0_readdata, avs_s0_waitrequest,
    input  core_we, core_oe, core_start, core_reg_sel, core_addr, core_wdata,
    output core_rdata, core_ready
  );
endinterface

// File: rtl/avalon_rsa_dma.sv
// Avalon-MM DMA front end for the byte-serial RSA core: key fetch once, then per block load/run/unload/write.
// Optional AVALON_RSA_DMA_IRQ_EN adds an irq output mirroring STATUS.done.
module avalon_rsa_dma #(
  parameter int DATA_W    = 256,
  parameter int CORE_W    = 8,
  parameter int ADDR_W    = 32,
  parameter int START_CYC = 2
) (
  input  logic clk,
  input  logic reset,
  avalon_rsa_dma_if.master bus
`ifdef AVALON_RSA_DMA_IRQ_EN
  ,
  output logic irq
`endif
);
  localparam int N    = DATA_W / CORE_W;
  localparam int B    = DATA_W / 8;
  localparam int CA_W = (N > 1) ? $clog2(N) : 1;
  localparam int IW   = CA_W + 1;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_KREQ   = 4'd1;
  localparam logic [3:0] S_KWAIT  = 4'd2;
  localparam logic [3:0] S_KLOAD  = 4'd3;
  localparam logic [3:0] S_MREQ   = 4'd4;
  localparam logic [3:0] S_MWAIT  = 4'd5;
  localparam logic [3:0] S_MLOAD  = 4'd6;
  localparam logic [3:0] S_START  = 4'd7;
  localparam logic [3:0] S_CALC   = 4'd8;
  localparam logic [3:0] S_UNLOAD = 4'd9;
  localparam logic [3:0] S_WREQ   = 4'd10;
  localparam logic [3:0] S_DONE   = 4'd11;

  logic [3:0]        r_state;
  logic              r_done;
  logic [ADDR_W-1:0] r_src, r_dst, r_addr, r_mptr, r_wptr;
  logic [15:0]       r_count, r_progress, r_m;
  logic              r_k;
  logic [DATA_W-1:0] r_beat, r_obuf;
  logic [IW-1:0]     r_idx;
  logic [3:0]        r_scnt;
  logic              r_first;

  logic              w_busy, w_go, w_clr, w_load_end;
  logic [CA_W-1:0]   w_widx, w_uidx;
  logic [IW-1:0]     w_idx_m1;

  assign w_busy     = (r_state != S_IDLE);
  assign w_go       = bus.avs_s0_write && (bus.avs_s0_address == 3'd0) && bus.avs_s0_writedata[0];
  assign w_clr      = bus.avs_s0_write && (bus.avs_s0_address == 3'd0) && bus.avs_s0_writedata[1];
  assign w_load_end = (r_idx == IW'(N - 1));
  assign w_widx     = r_idx[CA_W-1:0];
  assign w_idx_m1   = r_idx - 1'b1;
  assign w_uidx     = w_idx_m1[CA_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_src      <= '0;
      r_dst      <= '0;
      r_addr     <= '0;
      r_mptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_progress <= '0;
      r_m        <= '0;
      r_k        <= 1'b0;
      r_beat     <= '0;
      r_obuf     <= '0;
      r_idx      <= '0;
      r_scnt     <= '0;
      r_first    <= 1'b0;
    end else begin
      if (w_clr) r_done <= 1'b0;
      if (bus.avs_s0_write && !w_busy) begin
        case (bus.avs_s0_address)
          3'd2:    r_src   <= ADDR_W'(bus.avs_s0_writedata);
          3'd3:    r_dst   <= ADDR_W'(bus.avs_s0_writedata);
          3'd4:    r_count <= bus.avs_s0_writedata[15:0];
          default: ;
        endcase
      end
      case (r_state)
        S_IDLE: if (w_go) begin
          r_progress <= '0;
          if (r_count == 16'd0) begin
            r_state <= S_DONE;
          end else begin
            r_k     <= 1'b0;
            r_m     <= '0;
            r_addr  <= r_src;
            r_mptr  <= r_src + ADDR_W'(2 * B);
            r_wptr  <= r_dst;
            r_state <= S_KREQ;
          end
        end
        // Read data may return in the same cycle the request is accepted.
        S_KREQ, S_MREQ: if (!bus.avm_m0_waitrequest) begin
          if (r_state == S_MREQ) r_mptr <= r_mptr + ADDR_W'(B);
          if (bus.avm_m0_readdatavalid) begin
            r_beat  <= bus.avm_m0_readdata;
            r_idx   <= '0;
            r_state <= (r_state == S_KREQ) ? S_KLOAD : S_MLOAD;
          end else begin
            r_state <= (r_state == S_KREQ) ? S_KWAIT : S_MWAIT;
          end
        end
        S_KWAIT, S_MWAIT: if (bus.avm_m0_readdatavalid) begin
          r_beat  <= bus.avm_m0_readdata;
          r_idx   <= '0;
          r_state <= (r_state == S_KWAIT) ? S_KLOAD : S_MLOAD;
        end
        S_KLOAD: begin
          if (w_load_end) begin
            r_idx <= '0;
            if (r_k) begin
              r_addr  <= r_mptr;
              r_state <= S_MREQ;
            end else begin
              r_k     <= 1'b1;
              r_addr  <= r_src + ADDR_W'(B);
              r_state <= S_KREQ;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_MLOAD: begin
          if (w_load_end) begin
            r_idx   <= '0;
            r_scnt  <= '0;
            r_state <= S_START;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_START: begin
          if (r_scnt == 4'(START_CYC - 1)) begin
            r_first <= 1'b1;
            r_state <= S_CALC;
          end else begin
            r_scnt <= r_scnt + 1'b1;
          end
        end
        // A stale ready from the previous block is masked for one cycle.
        S_CALC: begin
          if (r_first) begin
            r_first <= 1'b0;
          end else if (bus.core_ready) begin
            r_idx   <= '0;
            r_state <= S_UNLOAD;
          end
        end
        S_UNLOAD: begin
          if (r_idx != '0) r_obuf[w_uidx*CORE_W +: CORE_W] <= bus.core_rdata;
          if (r_idx == IW'(N)) begin
            r_idx   <= '0;
            r_addr  <= r_wptr;
            r_state <= S_WREQ;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_WREQ: if (!bus.avm_m0_waitrequest) begin
          r_wptr     <= r_wptr + ADDR_W'(B);
          r_m        <= r_m + 16'd1;
          r_progress <= r_m + 16'd1;
          if (r_m + 16'd1 == r_count) begin
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_mptr;
            r_state <= S_MREQ;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.avm_m0_read      = (r_state == S_KREQ) || (r_state == S_MREQ);
  assign bus.avm_m0_write     = (r_state == S_WREQ);
  assign bus.avm_m0_address   = r_addr;
  assign bus.avm_m0_writedata = r_obuf;

  assign bus.core_we      = (r_state == S_KLOAD) || (r_state == S_MLOAD);
  assign bus.core_oe      = (r_state == S_UNLOAD) && (r_idx != IW'(N));
  assign bus.core_start   = (r_state == S_START);
  assign bus.core_reg_sel = (r_state == S_KLOAD) ? {1'b1, r_k} :
                            (r_state == S_MLOAD) ? 2'b01 : 2'b00;
  assign bus.core_addr    = (bus.core_we || bus.core_oe) ? w_widx : '0;
  assign bus.core_wdata   = bus.core_we ? r_beat[w_widx*CORE_W +: CORE_W] : '0;

  assign bus.avs_s0_waitrequest = 1'b0;

  always_comb begin
    bus.avs_s0_readdata = 32'd0;
    case (bus.avs_s0_address)
      3'd1:    bus.avs_s0_readdata = {30'd0, r_done, w_busy};
      3'd2:    bus.avs_s0_readdata = 32'(r_src);
      3'd3:    bus.avs_s0_readdata = 32'(r_dst);
      3'd4:    bus.avs_s0_readdata = {16'd0, r_count};
      3'd5:    bus.avs_s0_readdata = {16'd0, r_progress};
      default: bus.avs_s0_readdata = 32'd0;
    endcase
  end

`ifdef AVALON_RSA_DMA_IRQ_EN
  assign irq = r_done;
`endif
endmodule

// File: tb/tb_avalon_rsa_dma.sv
// Directed bench for avalon_rsa_dma: memory responder, toy core (out byte = msg byte + 1), CSR-driven steps.
module tb_avalon_rsa_dma;
  localparam int DATA_W = 256;
  localparam int CORE_W = 8;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  avalon_rsa_dma_if #(.DATA_W(DATA_W), .CORE_W(CORE_W), .ADDR_W(ADDR_W)) bus ();
`ifdef AVALON_RSA_DMA_IRQ_EN
  logic irq;
`endif

  avalon_rsa_dma #(.DATA_W(DATA_W), .CORE_W(CORE_W), .ADDR_W(ADDR_W), .START_CYC(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef AVALON_RSA_DMA_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  int n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // source pattern: byte j of the beat at address a is a[7:0]+j
  function automatic logic [255:0] pat(input logic [31:0] a);
    logic [255:0] p;
    for (int j = 0; j < 32; j++) p[j*8 +: 8] = a[7:0] + 8'(j);
    return p;
  endfunction

  function automatic logic [255:0] exp_out(input logic [31:0] a);
    logic [255:0] p;
    for (int j = 0; j < 32; j++) p[j*8 +: 8] = a[7:0] + 8'(j) + 8'd1;
    return p;
  endfunction

  // memory responder
  int wait_cfg = 0, lat_cfg = 1, wcnt = 0, pcnt = 0;
  logic [31:0]  paddr;
  logic [31:0]  rd_addr[$];
  logic [31:0]  wr_addr[$];
  logic [255:0] wr_data[$];

  always_comb bus.avm_m0_waitrequest = (bus.avm_m0_read || bus.avm_m0_write) && (wcnt < wait_cfg);

  always @(posedge clk) begin
    bus.avm_m0_readdatavalid <= 1'b0;
    if (reset) begin
      wcnt <= 0;
      pcnt <= 0;
      bus.avm_m0_readdata <= '0;
    end else begin
      if (pcnt != 0) begin
        pcnt <= pcnt - 1;
        if (pcnt == 1) begin
          bus.avm_m0_readdatavalid <= 1'b1;
          bus.avm_m0_readdata <= pat(paddr);
        end
      end
      if (bus.avm_m0_read || bus.avm_m0_write) begin
        if (bus.avm_m0_waitrequest) wcnt <= wcnt + 1;
        else begin
          wcnt <= 0;
          if (bus.avm_m0_read) begin
            rd_addr.push_back(bus.avm_m0_address);
            paddr <= bus.avm_m0_address;
            pcnt  <= lat_cfg;
          end else begin
            wr_addr.push_back(bus.avm_m0_address);
            wr_data.push_back(bus.avm_m0_writedata);
          end
        end
      end
    end
  end

  // toy core
  logic [7:0] key0[32], key1[32], msg[32];
  int we_cnt[4] = '{0, 0, 0, 0};
  int calc_delay = 4, ccnt = 0, start_run = 0, start_len = 0;

  always @(posedge clk) begin
    if (reset) begin
      bus.core_ready <= 1'b0;
      bus.core_rdata <= '0;
      ccnt <= 0;
    end else begin
      if (bus.core_we) begin
        case (bus.core_reg_sel)
          2'b10:   key0[bus.core_addr] <= bus.core_wdata;
          2'b11:   key1[bus.core_addr] <= bus.core_wdata;
          2'b01:   msg[bus.core_addr]  <= bus.core_wdata;
          default: ;
        endcase
        we_cnt[bus.core_reg_sel] <= we_cnt[bus.core_reg_sel] + 1;
      end
      bus.core_rdata <= bus.core_oe ? msg[bus.core_addr] + 8'd1 : 8'd0;
      if (bus.core_start) begin
        start_run <= start_run + 1;
        ccnt <= calc_delay;
        bus.core_ready <= 1'b0;
      end else begin
        if (start_run != 0) begin
          start_len <= start_run;
          start_run <= 0;
        end
        if (ccnt > 1) ccnt <= ccnt - 1;
        else if (ccnt == 1) begin
          ccnt <= 0;
          bus.core_ready <= 1'b1;
        end
      end
      if (bus.core_oe) bus.core_ready <= 1'b0;
    end
  end

  // protocol monitors: reg_sel idle outside loads, every we burst is N long
  int sel_bad = 0, run_bad = 0, we_run = 0;
  always @(negedge clk) begin
    if (!bus.core_we && bus.core_reg_sel != 2'b00) sel_bad <= sel_bad + 1;
    if (bus.core_we) we_run <= we_run + 1;
    else begin
      if (we_run != 0 && we_run != 32) run_bad <= run_bad + 1;
      we_run <= 0;
    end
  end

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_s0_address = a;
    bus.avs_s0_writedata = d;
    bus.avs_s0_write = 1'b1;
    @(negedge clk);
    bus.avs_s0_write = 1'b0;
    bus.avs_s0_address = 3'd0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    bus.avs_s0_address = a;
    #1 d = bus.avs_s0_readdata;
    bus.avs_s0_address = 3'd0;
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      csr_rd(3'd1, s);
      if (s[1]) break;
    end
    check(tag, {s[1], s[0]}, 2'b10);
  endtask

  logic [31:0] r;
  int rb, wb, w1, w2, w3;

  initial begin
    bus.avs_s0_address = 3'd0;
    bus.avs_s0_read = 1'b0;
    bus.avs_s0_write = 1'b0;
    bus.avs_s0_writedata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    csr_rd(3'd1, r); check("rst_status", r, 32'd0);
    csr_rd(3'd5, r); check("rst_progress", r, 32'd0);
    check("rst_strobes", {bus.avm_m0_read, bus.avm_m0_write, bus.core_we, bus.core_oe, bus.core_start}, 5'd0);
    check("rst_core_addr", {bus.core_reg_sel, bus.core_addr}, 7'd0);
`ifdef AVALON_RSA_DMA_IRQ_EN
    check("rst_irq", irq, 1'b0);
`endif

    // single block
    rb = rd_addr.size(); wb = wr_addr.size();
    w1 = we_cnt[1]; w2 = we_cnt[2]; w3 = we_cnt[3];
    csr_wr(3'd2, 32'h0);
    csr_wr(3'd3, 32'h1000);
    csr_wr(3'd4, 32'd1);
    csr_wr(3'd0, 32'h1);
    csr_rd(3'd1, r);
    check("go_busy_read", {r[0], bus.avm_m0_read, bus.avm_m0_address}, {2'b11, 32'h0});
    wait_done("t1_done");
    check("t1_nreads", rd_addr.size() - rb, 3);
    check("t1_raddr", {rd_addr[rb], rd_addr[rb+1], rd_addr[rb+2]}, {32'h0, 32'h20, 32'h40});
    check("t1_we_counts", {we_cnt[2] - w2, we_cnt[3] - w3, we_cnt[1] - w1}, {32'd32, 32'd32, 32'd32});
    check("t1_keys", {key0[5], key1[0], msg[31]}, {8'h05, 8'h20, 8'h5f});
    check("t1_start_len", start_len, 2);
    check("t1_nwrites", wr_addr.size() - wb, 1);
    check("t1_waddr", wr_addr[wb], 32'h1000);
    check("t1_wdata", wr_data[wb], exp_out(32'h40));
    r = wr_data[wb][255:224];
    check("t1_wdata_top", r, 32'h605f5e5d);
    csr_rd(3'd5, r); check("t1_progress", r, 32'd1);
`ifdef AVALON_RSA_DMA_IRQ_EN
    check("t1_irq", irq, 1'b1);
`endif

    // three blocks, slow memory; clear+go in one write
    wait_cfg = 3; lat_cfg = 5;
    rb = rd_addr.size(); wb = wr_addr.size();
    csr_wr(3'd2, 32'h100);
    csr_wr(3'd3, 32'h2000);
    csr_wr(3'd4, 32'd3);
    csr_wr(3'd0, 32'h3);
    csr_rd(3'd1, r); check("t2_clear_go", r[1:0], 2'b01);
`ifdef AVALON_RSA_DMA_IRQ_EN
    check("t2_irq_cleared", irq, 1'b0);
`endif
    wait_done("t2_done");
    check("t2_nreads", rd_addr.size() - rb, 5);
    check("t2_raddr", {rd_addr[rb], rd_addr[rb+1], rd_addr[rb+2], rd_addr[rb+4]},
          {32'h100, 32'h120, 32'h140, 32'h180});
    check("t2_nwrites", wr_addr.size() - wb, 3);
    check("t2_waddr", {wr_addr[wb], wr_addr[wb+1], wr_addr[wb+2]}, {32'h2000, 32'h2020, 32'h2040});
    check("t2_wdata2", wr_data[wb+2], exp_out(32'h180));
    csr_rd(3'd5, r); check("t2_progress", r, 32'd3);
    wait_cfg = 0; lat_cfg = 1;

    // zero count
    csr_wr(3'd0, 32'h2);
    rb = rd_addr.size(); wb = wr_addr.size();
    csr_wr(3'd4, 32'd0);
    csr_wr(3'd0, 32'h1);
    csr_rd(3'd1, r); check("t3_cycle1", r[1:0], 2'b01);
    @(negedge clk);
    csr_rd(3'd1, r); check("t3_cycle2_done", r[1:0], 2'b10);
    repeat (5) @(negedge clk);
    check("t3_no_traffic", {rd_addr.size() - rb, wr_addr.size() - wb}, 64'd0);

    // go and base write while busy are ignored
    csr_wr(3'd0, 32'h2);
    rb = rd_addr.size(); wb = wr_addr.size();
    csr_wr(3'd2, 32'h200);
    csr_wr(3'd3, 32'h3000);
    csr_wr(3'd4, 32'd1);
    csr_wr(3'd0, 32'h1);
    csr_wr(3'd2, 32'h400);
    csr_wr(3'd4, 32'd5);
    csr_wr(3'd0, 32'h1);
    wait_done("t4_done");
    repeat (20) @(negedge clk);
    csr_rd(3'd2, r); check("t4_src_kept", r, 32'h200);
    csr_rd(3'd4, r); check("t4_count_kept", r, 32'd1);
    check("t4_reads", {rd_addr.size() - rb, rd_addr[rb], rd_addr[rb+2]}, {32'd3, 32'h200, 32'h240});
    check("t4_write", {wr_addr.size() - wb, wr_addr[wb]}, {32'd1, 32'h3000});

    // reset during CALC, then clean restart
    csr_wr(3'd0, 32'h2);
    calc_delay = 40;
    csr_wr(3'd0, 32'h1);
    for (int i = 0; i < 500 && !bus.core_start; i++) @(negedge clk);
    check("t5_reached_start", bus.core_start, 1'b1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_strobes", {bus.avm_m0_read, bus.avm_m0_write, bus.core_start, bus.core_oe}, 4'd0);
    csr_rd(3'd1, r); check("t5_rst_status", r, 32'd0);
    csr_rd(3'd2, r); check("t5_rst_src", r, 32'd0);
    reset = 1'b0;
`ifdef AVALON_RSA_DMA_IRQ_EN
    check("t5_irq_low", irq, 1'b0);
`endif
    calc_delay = 4;
    rb = rd_addr.size(); wb = wr_addr.size();
    csr_wr(3'd2, 32'h300);
    csr_wr(3'd3, 32'h4000);
    csr_wr(3'd4, 32'd1);
    csr_wr(3'd0, 32'h1);
    check("t5_restart_read", {bus.avm_m0_read, bus.avm_m0_address}, {1'b1, 32'h300});
`ifdef AVALON_RSA_DMA_IRQ_EN
    check("t5_irq_busy", irq, 1'b0);
`endif
    wait_done("t5_done");
    check("t5_nreads", rd_addr.size() - rb, 3);
    check("t5_write", {wr_addr[wb], wr_data[wb]}, {32'h4000, exp_out(32'h340)});
`ifdef AVALON_RSA_DMA_IRQ_EN
    check("t5_irq_done", irq, 1'b1);
`endif

    check("reg_sel_idle", sel_bad, 0);
    check("we_burst_len", run_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
